// File: rtl/add_accumulate_ctrl.sv
// add_accumulate_ctrl
// Initiator-side controller for a start/complete adder handshake. Accepts a
// run of N operands on a valid/ready stream, hands each one to an external
// adder together with the running total, captures the returned sum, and
// reports the final total with a one-cycle result_valid pulse.
//
// Optional feature (macro ADD_TIMEOUT_EN): bounds each wait for add_complete
// to TIMEOUT_CYCLES cycles. On expiry the run ends early with the partial
// total and timeout_err set. Without the macro no wait counter is built and
// timeout_err is tied low.

module add_accumulate_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int COUNT_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   cfg_start,
  input  logic [COUNT_WIDTH-1:0] cfg_count,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   add_start,
  output logic [DATA_WIDTH-1:0]  add_addend1,
  output logic [DATA_WIDTH-1:0]  add_addend2,
  input  logic                   add_complete,
  input  logic [DATA_WIDTH-1:0]  add_sum,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   result_valid,
  output logic                   busy,
  output logic                   overflow,
  output logic                   timeout_err
);

  // A zero limit would make every wait expire before the adder can answer.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                 state_q;
  logic [DATA_WIDTH-1:0]  acc_q;
  logic [DATA_WIDTH-1:0]  operand_q;
  logic [COUNT_WIDTH-1:0] remaining_q;
  logic [DATA_WIDTH-1:0]  result_q;
  logic                   overflow_q;
  logic                   timeout_q;

`ifdef ADD_TIMEOUT_EN
  localparam int WaitCntWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WaitCntWidth-1:0] WaitLast = WaitCntWidth'(TIMEOUT_CYCLES - 1);
  logic [WaitCntWidth-1:0] wait_cnt_q;
`endif

  // Control FSM plus datapath registers. result_q is loaded on the transition
  // into DONE so that it already carries the final total while result_valid
  // (a decode of DONE) is high.
  // NOTE: every register here is assigned with <= so that all updates in a
  // cycle see the pre-edge values (e.g. the overflow compare uses the old acc).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      operand_q   <= '0;
      remaining_q <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef ADD_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            remaining_q <= cfg_count;
            acc_q       <= '0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
            if (cfg_count == '0) begin
              result_q <= '0;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (in_valid) begin
            operand_q <= in_data;
            state_q   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
`ifdef ADD_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (add_complete) begin
            acc_q       <= add_sum;
            overflow_q  <= overflow_q | (add_sum < acc_q);
            remaining_q <= remaining_q - COUNT_WIDTH'(1);
            if (remaining_q == COUNT_WIDTH'(1)) begin
              result_q <= add_sum;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_FETCH;
            end
          end
`ifdef ADD_TIMEOUT_EN
          else if (wait_cnt_q == WaitLast) begin
            // Adder never answered: keep the partial total and end the run.
            timeout_q   <= 1'b1;
            remaining_q <= '0;
            result_q    <= acc_q;
            state_q     <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitCntWidth'(1);
          end
`endif
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are either registers or decodes of the state register, so there
  // is no combinational path from any input to any output.
  assign in_ready     = (state_q == S_FETCH);
  assign add_start    = (state_q == S_ISSUE);
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign add_addend1  = acc_q;
  assign add_addend2  = operand_q;
  assign result       = result_q;
  assign overflow     = overflow_q;

`ifdef ADD_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_add_accumulate_ctrl.sv
// Testbench for add_accumulate_ctrl: directed runs plus randomized runs,
// with a behavioural adder responder and a running-sum reference model.
// Build with +define+ADD_TIMEOUT_EN to include the timeout scenario.

module tb_add_accumulate_ctrl;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int TO = 16;

  logic          clock        = 1'b0;
  logic          reset_n      = 1'b0;
  logic          cfg_start    = 1'b0;
  logic [CW-1:0] cfg_count    = '0;
  logic          in_valid     = 1'b0;
  logic [DW-1:0] in_data      = '0;
  logic          add_complete = 1'b0;
  logic [DW-1:0] add_sum      = '0;
  logic          in_ready;
  logic          add_start;
  logic [DW-1:0] add_addend1;
  logic [DW-1:0] add_addend2;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          busy;
  logic          overflow;
  logic          timeout_err;

  add_accumulate_ctrl #(
    .DATA_WIDTH    (DW),
    .COUNT_WIDTH   (CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cfg_start   (cfg_start),
    .cfg_count   (cfg_count),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .add_start   (add_start),
    .add_addend1 (add_addend1),
    .add_addend2 (add_addend2),
    .add_complete(add_complete),
    .add_sum     (add_sum),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Monitor / responder state, all updated on the falling edge.
  int            cyc            = 0;
  int            start_count    = 0;
  int            rv_count       = 0;
  int            resp_cnt       = 0;
  int            resp_lat       = 2;
  int            resp_limit     = 1000000;
  int            last_start_cyc = 0;
  int            rv_cyc         = 0;
  logic [DW-1:0] pend_sum       = '0;
  logic [DW-1:0] rv_result      = '0;
  logic          rv_ovf         = 1'b0;
  logic          rv_tmo         = 1'b0;
  logic [DW-1:0] cap_a1[$];
  logic [DW-1:0] cap_a2[$];

  // Adder responder (answers resp_lat cycles after add_start, stays silent
  // once more than resp_limit starts have been seen) and output monitor.
  always @(negedge clock) begin
    cyc++;
    add_complete = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        add_complete = 1'b1;
        add_sum      = pend_sum;
      end
    end
    if (add_start) begin
      start_count++;
      last_start_cyc = cyc;
      cap_a1.push_back(add_addend1);
      cap_a2.push_back(add_addend2);
      if (start_count <= resp_limit) begin
        resp_cnt = resp_lat;
        pend_sum = add_addend1 + add_addend2;
      end
    end
    if (result_valid) begin
      rv_count++;
      rv_cyc    = cyc;
      rv_result = result;
      rv_ovf    = overflow;
      rv_tmo    = timeout_err;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge(s).
  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic wait_rv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rv_count != 0) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  // One full run: reference model computes the expected addend pairs, total
  // and wrap flag; the DUT is driven and its observed behaviour compared.
  task automatic run(input string tag, input logic [DW-1:0] ops[$],
                     input int gap_at, input int lat, input bit b2b);
    logic [DW-1:0] e1[$];
    logic [DW-1:0] e2[$];
    logic [DW:0]   s;
    logic [DW-1:0] acc = '0;
    bit            ovf = 1'b0;
    bit            ok;
    int            sc;
    foreach (ops[i]) begin
      e1.push_back(acc);
      e2.push_back(ops[i]);
      s   = {1'b0, acc} + {1'b0, ops[i]};
      acc = s[DW-1:0];
      ovf = ovf | s[DW];
    end

    cap_a1.delete();
    cap_a2.delete();
    start_count = 0;
    rv_count    = 0;
    resp_lat    = lat;
    resp_limit  = 1000000;

    cfg_start = 1'b1;
    cfg_count = CW'(ops.size());
    step();
    cfg_start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'(ops.size() != 0));

    foreach (ops[i]) begin
      wait_ready(ok);
      if (!ok) begin
        check({tag, "_ready_timeout"}, 0, 1);
        return;
      end
      if (i == gap_at) begin
        sc = start_count;
        cfg_start = 1'b1;  // must be ignored outside IDLE
        cfg_count = '0;
        for (int g = 0; g < 5; g++) begin
          check({tag, "_gap_ready"}, 64'(in_ready), 1);
          step();
        end
        cfg_start = 1'b0;
        check({tag, "_gap_no_start"}, start_count, sc);
      end
      in_valid = 1'b1;
      in_data  = ops[i];
      step();
      in_valid = 1'b0;
    end

    wait_rv(ok);
    if (!ok) begin
      check({tag, "_rv_timeout"}, 0, 1);
      return;
    end
    if (!b2b) step(3);
    check({tag, "_rv_pulses"}, rv_count, 1);
    check({tag, "_starts"}, start_count, ops.size());
    if (cap_a1.size() == e1.size()) begin
      foreach (e1[i]) begin
        check({tag, "_addend1"}, cap_a1[i], e1[i]);
        check({tag, "_addend2"}, cap_a2[i], e2[i]);
      end
    end
    check({tag, "_result"}, rv_result, acc);
    check({tag, "_overflow"}, 64'(rv_ovf), 64'(ovf));
    check({tag, "_timeout"}, 64'(rv_tmo), 0);
  endtask

  initial begin
    logic [DW-1:0] q[$];
    bit            ok;
    int            n;

    // Reset state.
    step(2);
    check("rst_busy", 64'(busy), 0);
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_add_start", 64'(add_start), 0);
    check("rst_result", result, 0);
    check("rst_result_valid", 64'(result_valid), 0);
    check("rst_overflow", 64'(overflow), 0);
    reset_n = 1'b1;
    step(2);

    // Basic three-operand run.
    q = '{32'd5, 32'd7, 32'd9};
    run("basic", q, -1, 2, 1'b0);
    check("basic_total", rv_result, 32'd21);

    // Zero-length run: pulse on the cycle right after cfg_start is sampled.
    rv_count    = 0;
    start_count = 0;
    cfg_start   = 1'b1;
    cfg_count   = '0;
    step();
    cfg_start = 1'b0;
    check("zero_rv_now", 64'(result_valid), 1);
    check("zero_result", result, 0);
    step(2);
    check("zero_rv_count", rv_count, 1);
    check("zero_no_start", start_count, 0);
    check("zero_idle", 64'(busy), 0);

    // Wrap, then an immediate back-to-back run that must clear overflow.
    q = '{32'hFFFF_FFFF, 32'h0000_0002};
    run("wrap", q, -1, 1, 1'b1);
    check("wrap_total", rv_result, 32'h1);
    q = '{32'd1, 32'd1};
    run("after_wrap", q, -1, 3, 1'b0);
    check("after_wrap_total", rv_result, 32'd2);

    // Input stall of five cycles before the second operand.
    q = '{32'd100, 32'd23};
    run("gap", q, 1, 2, 1'b0);

    // Asynchronous reset in the middle of WAIT, then a stray complete.
    rv_count    = 0;
    start_count = 0;
    resp_lat    = 4;
    cfg_start   = 1'b1;
    cfg_count   = CW'(2);
    step();
    cfg_start = 1'b0;
    wait_ready(ok);
    in_valid = 1'b1;
    in_data  = 32'd10;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && start_count == 0; i++) step();
    check("mid_started", start_count, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_addend2", add_addend2, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_in_ready", 64'(in_ready), 0);
    step();
    reset_n = 1'b1;
    step(6);
    check("stray_idle", 64'(busy), 0);
    check("stray_no_rv", rv_count, 0);
    q = '{32'd3, 32'd4};
    run("post_rst", q, -1, 2, 1'b0);

`ifdef ADD_TIMEOUT_EN
    // Responder goes silent on the second operand.
    rv_count    = 0;
    start_count = 0;
    resp_lat    = 2;
    resp_limit  = 1;
    cfg_start   = 1'b1;
    cfg_count   = CW'(3);
    step();
    cfg_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_ready(ok);
      check("to_ready", 64'(ok), 1);
      in_valid = 1'b1;
      in_data  = (i == 0) ? 32'd4 : 32'd6;
      step();
      in_valid = 1'b0;
    end
    wait_rv(ok);
    check("to_rv_seen", 64'(ok), 1);
    check("to_result", rv_result, 32'd4);
    check("to_err", 64'(rv_tmo), 1);
    check("to_starts", start_count, 2);
    check("to_latency", rv_cyc - last_start_cyc, TO + 1);
    resp_limit = 1000000;
    step(3);
`endif

    // Randomized runs, including large operands to provoke wraps.
    for (int r = 0; r < 8; r++) begin
      q.delete();
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) q.push_back(32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
        else q.push_back(32'($urandom));
      end
      run("rand", q, -1, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
